// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared constants and types for the conv2 frame sequencer.
//   - default feature-map geometry, kernel size, address width and timeout
//   - FSM state encoding
//   - expected_outputs(): number of valid conv outputs for a W x H map
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int IMG_W_DEF   = 12;
  localparam int IMG_H_DEF   = 12;
  localparam int KSIZE_DEF   = 5;
  localparam int ADDR_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;

  localparam int DATA_W    = 8;
  localparam int OUT_CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A valid (no padding) KxK convolution yields (W-K+1)*(H-K+1) outputs.
  function automatic int expected_outputs(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// ---------------------------------------------------------------------------
// raster_addr_gen
// Raster-order row/column counter with a running linear address.
// The address is incremented alongside col/row, so no row*IMG_W multiply
// is needed; everything wraps to 0 after the last pixel.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   i_clr       return to pixel (0,0)
//   i_en        advance one pixel (address issued this cycle is o_addr)
//   o_addr      current linear address = row*IMG_W + col
//   o_last      current pixel is (IMG_H-1, IMG_W-1)
// ---------------------------------------------------------------------------
module raster_addr_gen #(
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              w_col_wrap;

  assign w_col_wrap = (r_col == COL_W'(IMG_W - 1));
  assign o_last     = w_col_wrap && (r_row == ROW_W'(IMG_H - 1));
  assign o_addr     = r_addr;

  // NOTE: registers are written with non-blocking (<=) so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_en) begin
      if (o_last) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv2_stream_ctrl.sv
// ---------------------------------------------------------------------------
// conv2_stream_ctrl
// Frame sequencer for conv2: on start, reads one IMG_W x IMG_H 3-channel
// pooled map from the pool1 buffer in raster order, streams it into conv2,
// counts conv2 outputs and flags completion, timeout or spurious outputs.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start                    one-cycle frame request (honoured only in IDLE)
//   hold                     back-pressure: suppresses new buffer reads
//   buf_rd_en / buf_rd_addr  buffer read strobe and raster address
//   buf_q1..3                buffer data, valid one cycle after buf_rd_en
//   cv_in_valid, cv_in_1..3  pixel stream into conv2
//   cv_out_valid             conv2 output strobe
//   busy                     high in FEED or DRAIN
//   done                     one-cycle frame-complete pulse
//   err                      sticky error (timeout / spurious / overrun)
//   out_cnt                  conv2 outputs counted this frame (saturating)
// ---------------------------------------------------------------------------
module conv2_stream_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int KSIZE   = KSIZE_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 buf_rd_en,
  output logic [ADDR_W-1:0]    buf_rd_addr,
  input  logic [DATA_W-1:0]    buf_q1,
  input  logic [DATA_W-1:0]    buf_q2,
  input  logic [DATA_W-1:0]    buf_q3,
  output logic                 cv_in_valid,
  output logic [DATA_W-1:0]    cv_in_1,
  output logic [DATA_W-1:0]    cv_in_2,
  output logic [DATA_W-1:0]    cv_in_3,
  input  logic                 cv_out_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [OUT_CNT_W-1:0] out_cnt
);

  localparam int EXP_CNT = expected_outputs(IMG_W, IMG_H, KSIZE);
  localparam int TMR_W   = $clog2(TIMEOUT + 1);

  state_t               r_state;
  logic                 r_done;
  logic                 r_err;
  logic [OUT_CNT_W-1:0] r_out_cnt;
  logic [TMR_W-1:0]     r_timer;
  logic                 r_cv_valid;
  logic [DATA_W-1:0]    r_hold_1;
  logic [DATA_W-1:0]    r_hold_2;
  logic [DATA_W-1:0]    r_hold_3;

  logic                 w_start_ok;
  logic                 w_issue;
  logic                 w_last;
  logic [ADDR_W-1:0]    w_addr;
  logic [OUT_CNT_W-1:0] w_cnt_next;
  logic                 w_reached;
  logic                 w_overrun;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_issue    = (r_state == ST_FEED) && !hold;

  // Saturating increment; the compare values include this cycle's pulse.
  assign w_cnt_next = (r_out_cnt == '1) ? r_out_cnt : r_out_cnt + OUT_CNT_W'(1);
  assign w_reached  = int'(w_cnt_next) >= EXP_CNT;
  assign w_overrun  = int'(w_cnt_next) > EXP_CNT;

  raster_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start_ok),
    .i_en   (w_issue),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  // Control FSM with registered done/err/out_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_out_cnt <= '0;
      r_timer   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_FEED;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
          end else if (cv_out_valid) begin
            r_err <= 1'b1;
          end
        end

        ST_FEED: begin
          r_timer <= '0;
          if (cv_out_valid) begin
            r_out_cnt <= w_cnt_next;
            if (w_overrun) r_err <= 1'b1;
          end
          if (w_issue && w_last) r_state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (cv_out_valid) begin
            r_out_cnt <= w_cnt_next;
            r_timer   <= '0;
            if (w_reached) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th consecutive idle cycle.
            r_err   <= 1'b1;
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          if (cv_out_valid) r_err <= 1'b1;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pixel stream. The buffer is a synchronous RAM, so its data arrives in
  // the same cycle as the delayed read strobe: pass it straight through while
  // valid and keep the last valid pixel on the bus otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cv_valid <= 1'b0;
      r_hold_1   <= '0;
      r_hold_2   <= '0;
      r_hold_3   <= '0;
    end else begin
      r_cv_valid <= w_issue;
      if (r_cv_valid) begin
        r_hold_1 <= buf_q1;
        r_hold_2 <= buf_q2;
        r_hold_3 <= buf_q3;
      end
    end
  end

  assign buf_rd_en   = w_issue;
  assign buf_rd_addr = w_addr;
  assign cv_in_valid = r_cv_valid;
  assign cv_in_1     = r_cv_valid ? buf_q1 : r_hold_1;
  assign cv_in_2     = r_cv_valid ? buf_q2 : r_hold_2;
  assign cv_in_3     = r_cv_valid ? buf_q3 : r_hold_3;
  assign busy        = (r_state == ST_FEED) || (r_state == ST_DRAIN);
  assign done        = r_done;
  assign err         = r_err;
  assign out_cnt     = r_out_cnt;

endmodule
